// File: rtl/data_bus_responder_pkg.sv
// Shared definitions for the data-bus responder: IO offsets, STATUS bit map
// and the address bit value that selects the IO block.
package data_bus_responder_pkg;

  typedef enum logic [1:0] {
    IO_LED    = 2'd0,
    IO_CYCLE  = 2'd1,
    IO_TXDATA = 2'd2,
    IO_STATUS = 2'd3
  } io_offset_e;

  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_OVF_BIT   = 2;

  // Value of the address MSB that routes an access to the IO block.
  localparam logic IO_SEL_VALUE = 1'b1;

  function automatic logic is_io_addr(input logic addr_msb);
    return addr_msb == IO_SEL_VALUE;
  endfunction

endpackage

// File: rtl/data_bus_tx_fifo.sv
// Transmit FIFO for the data-bus responder: circular buffer with count,
// sticky overflow and a valid/ready output stream.
module data_bus_tx_fifo
  import data_bus_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push_i,
  input  logic [DATA_WIDTH-1:0]              push_data_i,
  input  logic                               ovf_clr_i,
  output logic                               tx_valid_o,
  output logic [DATA_WIDTH-1:0]              tx_data_o,
  input  logic                               tx_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count_o,
  output logic [2:0]                         status_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  valid_q, valid_d;
  logic                  overflow_q, overflow_d;
  logic                  pop_s, accept_s;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
  always_comb begin
    pop_s    = valid_q && tx_ready_i;
    accept_s = push_i && ((count_q < CNT_W'(FIFO_DEPTH)) || pop_s);
    wr_ptr_d = accept_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != CNT_W'(0));
    if (push_i && !accept_s) begin
      overflow_d = 1'b1;
    end else if (ovf_clr_i) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_comb begin
    status_o                   = 3'b000;
    status_o[STATUS_FULL_BIT]  = (count_q == CNT_W'(FIFO_DEPTH));
    status_o[STATUS_EMPTY_BIT] = (count_q == CNT_W'(0));
    status_o[STATUS_OVF_BIT]   = overflow_q;
  end

  assign tx_valid_o = valid_q;
  assign tx_data_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/data_bus_responder.sv
// CPU data-memory target: word RAM plus LED, CYCLE, TXDATA and STATUS IO
// registers. The CYCLE counter exists only when DBUS_CYCLE_COUNTER_EN is defined.
module data_bus_responder
  import data_bus_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 4,
  parameter int LED_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] dataAddr,
  input  logic [DATA_WIDTH-1:0] dataWrData,
  input  logic                  dataWrEnable,
  output logic [DATA_WIDTH-1:0] dataRdData,
  output logic [LED_WIDTH-1:0]  led,
  output logic                  txValid,
  output logic [DATA_WIDTH-1:0] txData,
  input  logic                  txReady
);

  localparam int RAM_IDX_W = $clog2(RAM_WORDS);
  localparam int CNT_W     = $clog2(FIFO_DEPTH+1);

  logic                  io_sel_s, wr_io_s, ram_we_s;
  io_offset_e            io_off_s;
  logic [RAM_IDX_W-1:0]  ram_idx_s;
  logic                  led_we_s, fifo_push_s, ovf_clr_s;
  logic [LED_WIDTH-1:0]  led_q, led_d;
  logic [CNT_W-1:0]      fifo_count_s;
  logic [2:0]            fifo_status_s;
  logic [DATA_WIDTH-1:0] cycle_rd_s;
  logic [DATA_WIDTH-1:0] ram_q [RAM_WORDS];
  logic                  unused_addr_s;

  // Upper RAM address bits and middle IO bits alias by design.
  assign unused_addr_s = ^dataAddr;

  always_comb begin
    io_sel_s    = is_io_addr(dataAddr[ADDR_WIDTH-1]);
    io_off_s    = io_offset_e'(dataAddr[1:0]);
    ram_idx_s   = dataAddr[RAM_IDX_W-1:0];
    wr_io_s     = dataWrEnable && io_sel_s;
    ram_we_s    = dataWrEnable && !io_sel_s;
    led_we_s    = wr_io_s && (io_off_s == IO_LED);
    fifo_push_s = wr_io_s && (io_off_s == IO_TXDATA);
    ovf_clr_s   = wr_io_s && (io_off_s == IO_STATUS) && dataWrData[STATUS_OVF_BIT];
    led_d       = led_we_s ? dataWrData[LED_WIDTH-1:0] : led_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_q[ram_idx_s] <= dataWrData;
    end
  end

`ifdef DBUS_CYCLE_COUNTER_EN
  logic        cyc_clr_s;
  logic [31:0] cycle_q, cycle_d;

  always_comb begin
    cyc_clr_s = wr_io_s && (io_off_s == IO_CYCLE);
    cycle_d   = cyc_clr_s ? 32'd0 : cycle_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_q <= 32'd0;
    end else begin
      cycle_q <= cycle_d;
    end
  end

  assign cycle_rd_s = DATA_WIDTH'(cycle_q);
`else
  assign cycle_rd_s = '0;
`endif

  data_bus_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push_s),
    .push_data_i (dataWrData),
    .ovf_clr_i   (ovf_clr_s),
    .tx_valid_o  (txValid),
    .tx_data_o   (txData),
    .tx_ready_i  (txReady),
    .count_o     (fifo_count_s),
    .status_o    (fifo_status_s)
  );

  // Zero-wait-state read path; the CPU captures it in the same cycle.
  always_comb begin
    dataRdData = '0;
    if (io_sel_s) begin
      case (io_off_s)
        IO_LED:    dataRdData = DATA_WIDTH'(led_q);
        IO_CYCLE:  dataRdData = cycle_rd_s;
        IO_TXDATA: dataRdData = DATA_WIDTH'(fifo_count_s);
        IO_STATUS: dataRdData = DATA_WIDTH'(fifo_status_s);
        default:   dataRdData = '0;
      endcase
    end else begin
      dataRdData = ram_q[ram_idx_s];
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder: directed bus accesses plus a
// TX-stream scoreboard fed by a small model of the FIFO.
module tb_data_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dataAddr;
  logic [31:0] dataWrData;
  logic        dataWrEnable;
  logic [31:0] dataRdData;
  logic [7:0]  led;
  logic        txValid;
  logic [31:0] txData;
  logic        txReady;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  int          m_count = 0;

  data_bus_responder dut (
    .clk          (clk),
    .rst          (rst),
    .dataAddr     (dataAddr),
    .dataWrData   (dataWrData),
    .dataWrEnable (dataWrEnable),
    .dataRdData   (dataRdData),
    .led          (led),
    .txValid      (txValid),
    .txData       (txData),
    .txReady      (txReady)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
    dataAddr     = addr;
    dataWrData   = data;
    dataWrEnable = 1'b1;
    tick();
    dataWrEnable = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [15:0] addr, input logic [31:0] exp);
    dataAddr = addr;
    #1;
    check_eq(tag, dataRdData, exp);
  endtask

  // FIFO model: expected words are queued when a push is driven and accepted.
  always @(posedge clk) begin
    logic pop, push;
    if (!rst) begin
      m_count = 0;
      exp_q.delete();
    end else begin
      pop  = (m_count != 0) && txReady;
      push = dataWrEnable && dataAddr[15] && (dataAddr[1:0] == 2'd2);
      if (push && (m_count < 4 || pop)) begin
        exp_q.push_back(dataWrData);
        m_count++;
      end
      if (pop) begin
        void'(exp_q.pop_front());
        m_count--;
      end
    end
  end

  // Stream monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check_eq("txValid", {31'd0, txValid}, {31'd0, m_count != 0});
      if (m_count != 0 && exp_q.size() != 0) begin
        check_eq("txData", txData, exp_q[0]);
      end
    end
  end

  initial begin
    rst          = 1'b0;
    dataAddr     = 16'h0000;
    dataWrData   = 32'h0;
    dataWrEnable = 1'b0;
    txReady      = 1'b0;
    repeat (3) tick();

    check_eq("rst_led", {24'd0, led}, 32'h0);
    check_eq("rst_txValid", {31'd0, txValid}, 32'h0);
    bus_read("rst_led_rd", 16'h8000, 32'h0);
    bus_read("rst_cycle_rd", 16'h8001, 32'h0);
    bus_read("rst_count_rd", 16'h8002, 32'h0);
    bus_read("rst_status_rd", 16'h8003, 32'h2);

`ifdef DBUS_CYCLE_COUNTER_EN
    rst = 1'b1;
    repeat (10) tick();
    bus_read("cycle_10", 16'h8001, 32'd10);
    bus_write(16'h8001, 32'h1234);
    tick();
    bus_read("cycle_clr", 16'h8001, 32'd1);
    force dut.cycle_q = 32'hFFFF_FFFF;
    #2;
    release dut.cycle_q;
    tick();
    bus_read("cycle_wrap", 16'h8001, 32'd0);
`else
    rst = 1'b1;
    repeat (100) tick();
    bus_read("cycle_off", 16'h8001, 32'd0);
    bus_write(16'h8001, 32'h5555);
    bus_read("cycle_off_wr", 16'h8001, 32'd0);
`endif

    bus_write(16'h0005, 32'hDEADBEEF);
    bus_read("ram_rd", 16'h0005, 32'hDEADBEEF);
    bus_read("ram_alias", 16'h0405, 32'hDEADBEEF);
    bus_write(16'h03FF, 32'h12345678);
    bus_read("ram_top", 16'h7FFF, 32'h12345678);
    bus_read("ram_keep", 16'h0005, 32'hDEADBEEF);

    bus_write(16'h8000, 32'h1A5);
    check_eq("led_out", {24'd0, led}, 32'hA5);
    bus_read("led_rd", 16'h8000, 32'hA5);
    bus_read("led_alias", 16'h8FFC, 32'hA5);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_eq("led_reset", {24'd0, led}, 32'h0);

    txReady = 1'b0;
    for (int i = 1; i <= 4; i++) bus_write(16'h8002, i);
    bus_read("fifo_full_status", 16'h8003, 32'h1);
    bus_read("fifo_full_count", 16'h8002, 32'd4);
    bus_write(16'h8002, 32'd5);
    bus_read("ovf_status", 16'h8003, 32'h5);
    bus_read("ovf_count", 16'h8002, 32'd4);
    txReady = 1'b1;
    bus_write(16'h8002, 32'd6);
    bus_read("push_pop_count", 16'h8002, 32'd4);
    txReady = 1'b0;
    bus_write(16'h8003, 32'h4);
    bus_read("ovf_clr", 16'h8003, 32'h1);

    txReady = 1'b1;
    for (int i = 0; i < 20 && txValid; i++) tick();
    check_eq("drain_done", {31'd0, txValid}, 32'h0);
    check_eq("drain_model", m_count, 32'd0);
    bus_read("empty_status", 16'h8003, 32'h2);

    txReady = 1'b0;
    bus_write(16'h8002, 32'hA);
    bus_write(16'h8002, 32'hB);
    bus_read("mid_count", 16'h8002, 32'd2);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_eq("mid_rst_valid", {31'd0, txValid}, 32'h0);
    bus_read("mid_rst_status", 16'h8003, 32'h2);
    txReady = 1'b1;
    bus_write(16'h8002, 32'hC);
    tick();
    check_eq("post_rst_drain", {31'd0, txValid}, 32'h0);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
